// File: rtl/gelato_split_table.sv
// Per-warp SIMT split/reconvergence stack feeding next-PC, top index and ready bits to fetch.
// Optional divergence/join counters are built when GELATO_SPLIT_STATS_EN is defined.
module gelato_split_table #(
  parameter int          NUM_WARPS   = 4,
  parameter int          WARP_W      = 2,
  parameter int          NUM_THREADS = 32,
  parameter int          STACK_DEPTH = 4,
  parameter int          DEPTH_W     = 2,
  parameter logic [31:0] BOOT_PC     = 32'h0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           rdy,
  input  logic                           split_valid,
  input  logic [WARP_W-1:0]              split_warp_num,
  input  logic [DEPTH_W-1:0]             split_table_num,
  input  logic                           split_activate,
  input  logic                           split_stall,
  input  logic [31:0]                    split_updated_pc,
  output logic [NUM_THREADS-1:0]         split_thread_mask,
  input  logic                           res_valid,
  input  logic [WARP_W-1:0]              res_warp_num,
  input  logic                           res_is_branch,
  input  logic [31:0]                    res_pc,
  input  logic [NUM_THREADS-1:0]         res_taken_mask,
  input  logic [31:0]                    res_target,
  input  logic [31:0]                    res_reconv_pc,
  output logic [NUM_WARPS*32-1:0]        fetch_pc,
  output logic [NUM_WARPS*DEPTH_W-1:0]   fetch_top,
  output logic [NUM_WARPS-1:0]           fetch_ready,
  output logic [NUM_WARPS-1:0]           overflow_err,
  output logic [31:0]                    stat_splits,
  output logic [31:0]                    stat_joins
);

  logic [31:0]            pc_q   [NUM_WARPS][STACK_DEPTH];
  logic [31:0]            rpc_q  [NUM_WARPS][STACK_DEPTH];
  logic [NUM_THREADS-1:0] mask_q [NUM_WARPS][STACK_DEPTH];
  logic [DEPTH_W-1:0]     top_q  [NUM_WARPS];
  logic [NUM_WARPS-1:0]   stalled_q;
  logic [NUM_WARPS-1:0]   ovf_q;

  logic                   dec_fire;
  logic                   res_fire;
  logic                   dec_ok;
  logic [DEPTH_W-1:0]     dec_top;
  logic                   dec_pop;

  logic [DEPTH_W-1:0]     res_top;
  logic [DEPTH_W-1:0]     res_t1;
  logic [DEPTH_W-1:0]     res_t2;
  logic [NUM_THREADS-1:0] res_mask;
  logic [NUM_THREADS-1:0] res_tk;
  logic [31:0]            res_seq;
  logic                   res_divergent;
  logic                   res_room;

  assign dec_fire = split_valid & rdy;
  assign res_fire = res_valid & rdy;
  // A resolution owns its warp for the cycle; a colliding decode update is dropped.
  assign dec_ok   = dec_fire & ~(res_fire & (res_warp_num == split_warp_num));

  always_comb begin
    dec_top = top_q[split_warp_num];
    dec_pop = split_activate
              && (split_table_num == dec_top)
              && (split_updated_pc == rpc_q[split_warp_num][dec_top])
              && (dec_top != '0);
  end

  always_comb begin
    res_top       = top_q[res_warp_num];
    res_t1        = res_top + DEPTH_W'(1);
    res_t2        = res_top + DEPTH_W'(2);
    res_mask      = mask_q[res_warp_num][res_top];
    res_tk        = res_taken_mask & res_mask;
    res_seq       = res_pc + 32'd4;
    res_divergent = res_is_branch && (res_tk != '0) && (res_tk != res_mask);
    res_room      = (int'(res_top) + 2) <= (STACK_DEPTH - 1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        for (int e = 0; e < STACK_DEPTH; e++) begin
          pc_q[w][e]   <= '0;
          rpc_q[w][e]  <= '0;
          mask_q[w][e] <= '0;
        end
        pc_q[w][0]   <= BOOT_PC;
        rpc_q[w][0]  <= 32'hFFFF_FFFF;
        mask_q[w][0] <= '1;
        top_q[w]     <= '0;
      end
      stalled_q <= '0;
      ovf_q     <= '0;
    end else begin
      if (dec_ok) begin
        if (split_activate) begin
          if (dec_pop)
            top_q[split_warp_num] <= dec_top - DEPTH_W'(1);
          else
            pc_q[split_warp_num][split_table_num] <= split_updated_pc;
        end
        if (split_stall)
          stalled_q[split_warp_num] <= 1'b1;
      end

      if (res_fire) begin
        if (res_divergent) begin
          // Divergent split: top becomes the taken path, below it the fall-through, then the join.
          if (res_room) begin
            pc_q[res_warp_num][res_top]  <= res_reconv_pc;
            pc_q[res_warp_num][res_t1]   <= res_seq;
            rpc_q[res_warp_num][res_t1]  <= res_reconv_pc;
            mask_q[res_warp_num][res_t1] <= res_mask & ~res_tk;
            pc_q[res_warp_num][res_t2]   <= res_target;
            rpc_q[res_warp_num][res_t2]  <= res_reconv_pc;
            mask_q[res_warp_num][res_t2] <= res_tk;
            top_q[res_warp_num]          <= res_t2;
            stalled_q[res_warp_num]      <= 1'b0;
          end else begin
            ovf_q[res_warp_num]     <= 1'b1;
            stalled_q[res_warp_num] <= 1'b1;
          end
        end else begin
          pc_q[res_warp_num][res_top] <= (res_is_branch && (res_tk != '0)) ? res_target : res_seq;
          stalled_q[res_warp_num]     <= 1'b0;
        end
      end
    end
  end

`ifdef GELATO_SPLIT_STATS_EN
  logic [31:0] splits_q;
  logic [31:0] joins_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      splits_q <= '0;
      joins_q  <= '0;
    end else begin
      if (res_fire && res_divergent && res_room)
        splits_q <= splits_q + 32'd1;
      if (dec_ok && dec_pop)
        joins_q <= joins_q + 32'd1;
    end
  end

  assign stat_splits = splits_q;
  assign stat_joins  = joins_q;
`else
  assign stat_splits = '0;
  assign stat_joins  = '0;
`endif

  assign split_thread_mask = mask_q[split_warp_num][split_table_num];
  assign fetch_ready       = ~stalled_q & ~ovf_q;
  assign overflow_err      = ovf_q;

  for (genvar g = 0; g < NUM_WARPS; g++) begin : g_fetch
    assign fetch_pc[g*32 +: 32]          = pc_q[g][top_q[g]];
    assign fetch_top[g*DEPTH_W +: DEPTH_W] = top_q[g];
  end

endmodule

// File: tb/tb_gelato_split_table.sv
// Directed self-checking bench for gelato_split_table with hand-computed expectations.
// Stat counter expectations follow GELATO_SPLIT_STATS_EN.
module tb_gelato_split_table;

  logic        clk;
  logic        rst_n;
  logic        rdy;
  logic        split_valid;
  logic [1:0]  split_warp_num;
  logic [1:0]  split_table_num;
  logic        split_activate;
  logic        split_stall;
  logic [31:0] split_updated_pc;
  logic [31:0] split_thread_mask;
  logic        res_valid;
  logic [1:0]  res_warp_num;
  logic        res_is_branch;
  logic [31:0] res_pc;
  logic [31:0] res_taken_mask;
  logic [31:0] res_target;
  logic [31:0] res_reconv_pc;
  logic [127:0] fetch_pc;
  logic [7:0]  fetch_top;
  logic [3:0]  fetch_ready;
  logic [3:0]  overflow_err;
  logic [31:0] stat_splits;
  logic [31:0] stat_joins;

  int errors = 0;
  int checks = 0;

  gelato_split_table dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .rdy               (rdy),
    .split_valid       (split_valid),
    .split_warp_num    (split_warp_num),
    .split_table_num   (split_table_num),
    .split_activate    (split_activate),
    .split_stall       (split_stall),
    .split_updated_pc  (split_updated_pc),
    .split_thread_mask (split_thread_mask),
    .res_valid         (res_valid),
    .res_warp_num      (res_warp_num),
    .res_is_branch     (res_is_branch),
    .res_pc            (res_pc),
    .res_taken_mask    (res_taken_mask),
    .res_target        (res_target),
    .res_reconv_pc     (res_reconv_pc),
    .fetch_pc          (fetch_pc),
    .fetch_top         (fetch_top),
    .fetch_ready       (fetch_ready),
    .overflow_err      (overflow_err),
    .stat_splits       (stat_splits),
    .stat_joins        (stat_joins)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pcOf(input int w);
    return fetch_pc[w*32 +: 32];
  endfunction

  function automatic logic [31:0] topOf(input int w);
    return {30'd0, fetch_top[w*2 +: 2]};
  endfunction

  task automatic lookupMask(input int w, input int e, input logic [31:0] exp, input string tag);
    split_warp_num  = 2'(w);
    split_table_num = 2'(e);
    #1;
    checkOutput(tag, split_thread_mask, exp);
  endtask

  task automatic setUpdate(input int w, input int e, input logic act, input logic stall,
                           input logic [31:0] pc);
    split_valid      = 1'b1;
    split_warp_num   = 2'(w);
    split_table_num  = 2'(e);
    split_activate   = act;
    split_stall      = stall;
    split_updated_pc = pc;
  endtask

  task automatic setResolve(input int w, input logic br, input logic [31:0] pc,
                            input logic [31:0] tk, input logic [31:0] tgt, input logic [31:0] rpc);
    res_valid      = 1'b1;
    res_warp_num   = 2'(w);
    res_is_branch  = br;
    res_pc         = pc;
    res_taken_mask = tk;
    res_target     = tgt;
    res_reconv_pc  = rpc;
  endtask

  // One clock edge with the staged requests, then requests are withdrawn and outputs settle.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
    split_valid = 1'b0;
    res_valid   = 1'b0;
  endtask

  logic [31:0] expSplits;
  logic [31:0] expJoins;

  initial begin
    rst_n = 1'b0; rdy = 1'b1;
    split_valid = 0; split_warp_num = 0; split_table_num = 0; split_activate = 0;
    split_stall = 0; split_updated_pc = 0;
    res_valid = 0; res_warp_num = 0; res_is_branch = 0; res_pc = 0;
    res_taken_mask = 0; res_target = 0; res_reconv_pc = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int w = 0; w < 4; w++) begin
      checkOutput($sformatf("rst_pc%0d", w), pcOf(w), 32'h0);
      checkOutput($sformatf("rst_top%0d", w), topOf(w), 32'h0);
      lookupMask(w, 0, 32'hFFFF_FFFF, $sformatf("rst_mask%0d", w));
    end
    checkOutput("rst_ready", {28'd0, fetch_ready}, 32'hF);
    checkOutput("rst_ovf", {28'd0, overflow_err}, 32'h0);
    checkOutput("rst_splits", stat_splits, 32'h0);

    setUpdate(1, 0, 1'b1, 1'b0, 32'h104);
    applyStimulus();
    checkOutput("upd_pc1", pcOf(1), 32'h104);
    checkOutput("upd_pc0", pcOf(0), 32'h0);
    checkOutput("upd_pc2", pcOf(2), 32'h0);

    setUpdate(0, 0, 1'b0, 1'b1, 32'h0);
    applyStimulus();
    checkOutput("stall_ready", {28'd0, fetch_ready}, 32'hE);
    checkOutput("stall_pc0", pcOf(0), 32'h0);

    rdy = 1'b0;
    setResolve(0, 1'b1, 32'h20, 32'hFFFF_FFFF, 32'h80, 32'h0);
    applyStimulus();
    checkOutput("rdy0_ready", {28'd0, fetch_ready}, 32'hE);
    checkOutput("rdy0_pc0", pcOf(0), 32'h0);
    rdy = 1'b1;

    setResolve(0, 1'b1, 32'h20, 32'hFFFF_FFFF, 32'h80, 32'h0);
    applyStimulus();
    checkOutput("alltk_pc0", pcOf(0), 32'h80);
    checkOutput("alltk_ready", {28'd0, fetch_ready}, 32'hF);
    checkOutput("alltk_top0", topOf(0), 32'h0);

    setResolve(1, 1'b1, 32'h50, 32'h0, 32'h900, 32'h0);
    applyStimulus();
    checkOutput("notk_pc1", pcOf(1), 32'h54);

    setResolve(1, 1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'h900, 32'h0);
    applyStimulus();
    checkOutput("wrap_pc1", pcOf(1), 32'h0);

    setResolve(2, 1'b1, 32'h40, 32'h0000_FFFF, 32'h100, 32'h200);
    setUpdate(1, 0, 1'b1, 1'b0, 32'h500);
    applyStimulus();
    checkOutput("div_top2", topOf(2), 32'h2);
    checkOutput("div_pc2", pcOf(2), 32'h100);
    checkOutput("div_other_pc1", pcOf(1), 32'h500);
    lookupMask(2, 2, 32'h0000_FFFF, "div_mask_e2");
    lookupMask(2, 1, 32'hFFFF_0000, "div_mask_e1");
    lookupMask(2, 0, 32'hFFFF_FFFF, "div_mask_e0");
`ifdef GELATO_SPLIT_STATS_EN
    expSplits = 32'd1;
`else
    expSplits = 32'd0;
`endif
    checkOutput("div_splits", stat_splits, expSplits);

    setUpdate(2, 2, 1'b1, 1'b0, 32'h200);
    applyStimulus();
    checkOutput("pop1_top2", topOf(2), 32'h1);
    checkOutput("pop1_pc2", pcOf(2), 32'h44);

    setUpdate(2, 1, 1'b1, 1'b0, 32'h200);
    applyStimulus();
    checkOutput("pop2_top2", topOf(2), 32'h0);
    checkOutput("pop2_pc2", pcOf(2), 32'h200);
`ifdef GELATO_SPLIT_STATS_EN
    expJoins = 32'd2;
`else
    expJoins = 32'd0;
`endif
    checkOutput("pop2_joins", stat_joins, expJoins);

    setResolve(3, 1'b1, 32'h60, 32'h0000_FFFF, 32'h400, 32'h500);
    applyStimulus();
    checkOutput("fill_top3", topOf(3), 32'h2);
    checkOutput("fill_pc3", pcOf(3), 32'h400);

    setResolve(3, 1'b1, 32'h400, 32'h0000_00FF, 32'h600, 32'h700);
    applyStimulus();
    checkOutput("ovf_err", {28'd0, overflow_err}, 32'h8);
    checkOutput("ovf_ready", {28'd0, fetch_ready}, 32'h7);
    checkOutput("ovf_top3", topOf(3), 32'h2);
    checkOutput("ovf_pc3", pcOf(3), 32'h400);
`ifdef GELATO_SPLIT_STATS_EN
    expSplits = 32'd2;
`else
    expSplits = 32'd0;
`endif
    checkOutput("ovf_splits", stat_splits, expSplits);

    setUpdate(0, 0, 1'b1, 1'b1, 32'h999);
    setResolve(0, 1'b0, 32'h300, 32'h0, 32'h0, 32'h0);
    applyStimulus();
    checkOutput("same_pc0", pcOf(0), 32'h304);
    checkOutput("same_ready", {28'd0, fetch_ready}, 32'h7);

    setResolve(1, 1'b1, 32'h10, 32'h0000_0001, 32'h700, 32'h800);
    applyStimulus();
    checkOutput("pre_rst_top1", topOf(1), 32'h2);

    rst_n = 1'b0;
    applyStimulus();
    rst_n = 1'b1;
    for (int w = 0; w < 4; w++) begin
      checkOutput($sformatf("mid_rst_pc%0d", w), pcOf(w), 32'h0);
      checkOutput($sformatf("mid_rst_top%0d", w), topOf(w), 32'h0);
    end
    checkOutput("mid_rst_ready", {28'd0, fetch_ready}, 32'hF);
    checkOutput("mid_rst_ovf", {28'd0, overflow_err}, 32'h0);
    checkOutput("mid_rst_splits", stat_splits, 32'h0);
    checkOutput("mid_rst_joins", stat_joins, 32'h0);
    lookupMask(1, 1, 32'h0, "mid_rst_mask_e1");
    lookupMask(1, 0, 32'hFFFF_FFFF, "mid_rst_mask_e0");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gelato_split_table.md
Name: gelato_split_table

Overview:
- Per-warp SIMT split (reconvergence) stack.
- Responder on the decode↔split-table interface:
  - returns the active thread mask for a decoded instruction;
  - accepts PC/stall updates from decode;
  - accepts branch/AUIPC resolutions from execute.
- Drives per-warp next PC, top-of-stack index and ready bits to the warp scheduler / I-Fetch.

Parameters:
- NUM_WARPS, 4, number of warps.
- WARP_W, 2, warp index width (clog2 NUM_WARPS).
- NUM_THREADS, 32, threads per warp (mask width).
- STACK_DEPTH, 4, entries per warp stack.
- DEPTH_W, 2, stack index width (clog2 STACK_DEPTH).
- BOOT_PC, 32'h0, PC loaded into every warp at reset.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- rdy  in  1  global enable; no state change when 0.
- split_valid  in  1  update request from decode.
- split_warp_num  in  WARP_W  warp of request / mask lookup.
- split_table_num  in  DEPTH_W  stack entry of request / mask lookup.
- split_activate  in  1  1 = write split_updated_pc; 0 = no PC write.
- split_stall  in  1  1 = stall warp until resolution.
- split_updated_pc  in  32  next PC from decode.
- split_thread_mask  out  NUM_THREADS  mask of entry [split_warp_num][split_table_num]; combinational.
- res_valid  in  1  resolution from execute.
- res_warp_num  in  WARP_W  resolved warp.
- res_is_branch  in  1  1 = branch, 0 = AUIPC-type resume.
- res_pc  in  32  PC of the resolved instruction.
- res_taken_mask  in  NUM_THREADS  threads taking the branch.
- res_target  in  32  branch target.
- res_reconv_pc  in  32  reconvergence PC.
- fetch_pc  out  NUM_WARPS*32  top-entry PC per warp.
- fetch_top  out  NUM_WARPS*DEPTH_W  top index per warp.
- fetch_ready  out  NUM_WARPS  warp not stalled and no error.
- overflow_err  out  NUM_WARPS  sticky stack overflow per warp.
- stat_splits  out  32  divergent branches (optional feature).
- stat_joins  out  32  reconvergence pops (optional feature).

Behaviour:
- Entry fields: {pc[31:0], rpc[31:0], mask[NUM_THREADS-1:0]}. Per warp: top pointer, stalled bit.
- Reset (rst_n=0 at posedge clk), all warps:
  - top=0; entry0 = {BOOT_PC, 32'hFFFF_FFFF, all ones}; other entries 0;
  - stalled=0; overflow_err=0; stats=0;
  - fetch_ready=all ones. Reset mid-operation discards all state.
- split_thread_mask: pure combinational read, 0-cycle latency.
- Decode update (split_valid & rdy) on warp w, entry e; applied next edge:
  - split_activate=1: entry[e].pc <= split_updated_pc;
  - if e==top and split_updated_pc==entry[top].rpc: pop instead (top <= top-1; join count +1). Never pop below 0.
  - split_stall=1: stalled[w] <= 1 (PC write still obeys split_activate).
- Resolution (res_valid & rdy) on warp w; clears stalled[w]. Let T=top, M=entry[T].mask, tk=res_taken_mask & M.
  - res_is_branch=0: entry[T].pc <= res_pc+4.
  - tk==0: entry[T].pc <= res_pc+4.
  - tk==M: entry[T].pc <= res_target.
  - Otherwise (divergent), requires T+2 <= STACK_DEPTH-1:
    - entry[T].pc <= res_reconv_pc (rpc, mask kept);
    - entry[T+1] <= {res_pc+4, res_reconv_pc, M & ~tk};
    - entry[T+2] <= {res_target, res_reconv_pc, tk};
    - top <= T+2; split count +1.
  - Divergent with insufficient depth: no push; overflow_err[w] <= 1 (sticky until reset); stalled[w] stays 1.
- Simultaneous events:
  - decode update and resolution on different warps: both applied the same cycle.
  - same warp: resolution applied, decode update dropped.
- fetch_ready[w] = !stalled[w] & !overflow_err[w]; registered state, outputs reflect it 1 cycle after the causing edge.
- PC arithmetic is 32-bit, wrap-around, no carry.

Optional Feature:
- GELATO_SPLIT_STATS_EN defined:
  - stat_splits increments on each divergent push;
  - stat_joins increments on each reconvergence pop;
  - both 32-bit, wrap at 2^32.
- Not defined: both outputs tied to 0; no counter logic.

Test Plan:
- Reset, then release → fetch_pc all 0, fetch_top all 0, fetch_ready 4'b1111, split_thread_mask 32'hFFFF_FFFF for any warp/entry 0.
- Update w1, e0, activate=1, pc 0x104, stall=0 → next cycle fetch_pc[w1]=0x104; other warps unchanged.
- Update w0, stall=1 → fetch_ready[0]=0. Resolve w0, non-divergent, res_pc 0x20, tk=all ones, target 0x80 → pc 0x80, ready 1, top 0.
- Divergent w2, res_pc 0x40, tk=32'h0000_FFFF, target 0x100, reconv 0x200:
  - top=2; entry2 = {0x100, mask 0x0000_FFFF}; entry1 = {0x44, mask 0xFFFF_0000}; entry0.pc=0x200; stat_splits=1 (feature on).
  - Then update e2 pc 0x200 → top=1; then update e1 pc 0x200 → top=0, stat_joins=2.
- Fill w3 to top=2, then another divergent resolve → overflow_err[3]=1, fetch_ready[3]=0, top stays 2.
- Same-cycle decode update and resolution on w0 → only resolution effect visible. Assert rst_n=0 mid-divergence → all state at reset values next cycle.
